seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 23 ++
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider_div_step.sv | 32 +++
 rtl/seq_divider.sv | 142 ++++++++++++++
 tb/tb_seq_divider.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential RV32M divider: operation codes and FSM states.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    SPECIAL
  } state_t;

  // DIV and REM treat their operands as two's complement; the U variants do not.
  function automatic logic is_signed_op(input op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the core (master) and the divider (slave).
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int N = 32
);

  logic         start;
  op_t          op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (
    output start, op, dividend, divisor,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor,
    output busy, done, result
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor,
// keep the difference only when the N+1-bit subtract produces no borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N:0]   rem,
  input  logic         qbit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_next,
  output logic         qbit
);

  logic [N:0]   rem_shift;
  logic [N:0]   divisor_inv;
  logic [N+1:0] sum;
  logic         unused_rem_top;

  assign rem_shift   = {rem[N-1:0], qbit_in};
  assign divisor_inv = ~{1'b0, divisor};

  // Carry-propagate add of the inverted divisor with cin=1; the carry-out is "no borrow".
  assign sum = {1'b0, rem_shift} + {1'b0, divisor_inv} + {{(N+1){1'b0}}, 1'b1};

  assign qbit     = sum[N+1];
  assign rem_next = qbit ? sum[N:0] : rem_shift;

  // The remainder never exceeds the divisor, so its top bit is always clear on entry.
  assign unused_rem_top = rem[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per clock,
// single-cycle results for divide-by-zero and signed overflow.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int           CW      = $clog2(N);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          special_case;
  logic          is_signed;
  logic          dvd_neg;
  logic          dvs_neg;
  logic [N-1:0]  dvd_abs;
  logic [N-1:0]  dvs_abs;

  logic [N:0]    rem;
  logic [N:0]    rem_step;
  logic [N-1:0]  q;
  logic          qbit;
  logic [N-1:0]  dvsr;
  logic [CW-1:0] cnt;
  logic          q_neg;
  logic          r_neg;
  logic          div_zero;
  op_t           op_r;
  logic [N-1:0]  result_r;
  logic          done_r;

  logic [N-1:0]  q_fixed;
  logic [N-1:0]  r_fixed;
  logic [N-1:0]  special_result;
  logic          unused_rem_top;

  assign is_signed    = is_signed_op(bus.op);
  assign dvd_neg      = is_signed & bus.dividend[N-1];
  assign dvs_neg      = is_signed & bus.divisor[N-1];
  assign dvd_abs      = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_abs      = dvs_neg ? -bus.divisor : bus.divisor;
  assign special_case = (bus.divisor == '0) ||
                        (is_signed && bus.dividend == MIN_NEG && bus.divisor == '1);

  div_step #(.N(N)) u_step (
    .rem      (rem),
    .qbit_in  (q[N-1]),
    .divisor  (dvsr),
    .rem_next (rem_step),
    .qbit     (qbit)
  );

  assign q_fixed        = (q_neg && op_r == OP_DIV) ? -q : q;
  assign r_fixed        = (r_neg && op_r == OP_REM) ? -rem[N-1:0] : rem[N-1:0];
  assign unused_rem_top = rem[N];

  // Special-case accepts park the raw dividend in q, since divide-by-zero REM returns it.
  always_comb begin
    if (div_zero) special_result = op_r[1] ? q : '1;
    else          special_result = op_r[1] ? '0 : MIN_NEG;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = special_case ? SPECIAL : RUN;
        end
      end
      RUN:     if (cnt == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      SPECIAL: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      q        <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      op_r     <= OP_DIV;
      result_r <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rem      <= '0;
            cnt      <= '0;
            op_r     <= bus.op;
            q_neg    <= dvd_neg ^ dvs_neg;
            r_neg    <= dvd_neg;
            div_zero <= (bus.divisor == '0);
            q        <= special_case ? bus.dividend : dvd_abs;
            dvsr     <= dvs_abs;
          end
        end
        RUN: begin
          rem <= rem_step;
          q   <= {q[N-2:0], qbit};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          result_r <= op_r[1] ? r_fixed : q_fixed;
          done_r   <= 1'b1;
        end
        SPECIAL: begin
          result_r <= special_result;
          done_r   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: normal, signed, special-case, ignored-start
// and mid-operation reset scenarios with hand-computed results and latencies.
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   testCount = 0;
  int   failCount = 0;

  seq_divider_if #(.N(32)) bus ();

  seq_divider #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Called just after a clock edge; the next edge is the accept edge. Returns the number of
  // edges from accept to the done pulse and whether busy stayed high until then.
  task automatic applyStimulus(input op_t op, input logic [31:0] a, input logic [31:0] b,
                               input bit noise, output int lat, output logic [31:0] res,
                               output logic busyOk);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.op       = OP_REM;
    bus.dividend = 32'hA5A5_5A5A;
    bus.divisor  = 32'h0000_0000;
    lat    = 0;
    busyOk = 1'b1;
    while (!bus.done && lat < 60) begin
      if (!bus.busy) busyOk = 1'b0;
      if (noise && (lat == 4 || lat == 19)) begin
        bus.start    = 1'b1;
        bus.op       = OP_DIVU;
        bus.dividend = 32'd7;
        bus.divisor  = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    if (bus.busy) busyOk = 1'b0;
    res = bus.result;
  endtask

  task automatic runCase(input string tag, input op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    int          lat;
    logic [31:0] res;
    logic        busyOk;
    applyStimulus(op, a, b, 1'b0, lat, res, busyOk);
    checkOutput({tag, "_result"}, res, expRes);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_busy"}, {31'd0, busyOk}, 32'd1);
  endtask

  initial begin
    int          lat;
    int          doneSeen;
    logic [31:0] res;
    logic        busyOk;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.op       = OP_DIV;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",   {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_done",   {31'd0, bus.done}, 32'd0);
    checkOutput("reset_result", bus.result,        32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: the second request is issued in the done cycle of the first.
    runCase("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    runCase("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2,  33);

    runCase("div_m7_2",  OP_DIV, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    runCase("rem_m7_2",  OP_REM, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    runCase("div_7_m2",  OP_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    runCase("rem_7_m2",  OP_REM, 32'd7,         32'hFFFF_FFFE, 32'd1,        33);

    runCase("divu_by0",  OP_DIVU, 32'd5,         32'd0, 32'hFFFF_FFFF, 1);
    runCase("remu_by0",  OP_REMU, 32'd5,         32'd0, 32'd5,         1);
    runCase("div_by0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    runCase("rem_by0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);

    runCase("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runCase("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    runCase("divu_ovf",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);
    runCase("remu_ovf",  OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

    // Starts pulsed while busy must be dropped, leaving exactly one done pulse.
    applyStimulus(OP_DIVU, 32'd1000, 32'd10, 1'b1, lat, res, busyOk);
    checkOutput("ignore_result",  res,             32'd100);
    checkOutput("ignore_latency", 32'(lat),        32'd33);
    checkOutput("ignore_busy",    {31'd0, busyOk}, 32'd1);
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) doneSeen++;
    end
    checkOutput("ignore_no_extra", 32'(doneSeen), 32'd0);

    // Reset ten edges into a long division aborts it without a done pulse.
    bus.start    = 1'b1;
    bus.op       = OP_DIVU;
    bus.dividend = 32'hFFFF_FFFF;
    bus.divisor  = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_busy",   {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_done",   {31'd0, bus.done}, 32'd0);
    checkOutput("abort_result", bus.result,        32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);

    runCase("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
